// File: rtl/operand_accum_if.sv
// Bundles the tracker-side snapshot signals and the valid/ready result port of operand_accum.
interface operand_accum_if #(
    parameter int unsigned W = 8
) ();
    logic             full;
    logic [4*W-1:0]   op_data;
    logic [1:0]       mode;
    logic             clear;
    logic             busy;
    logic [W+1:0]     result;
    logic             result_valid;
    logic             result_ready;

    // master: tracker plus result consumer; slave: the accumulator
    modport master (
        output full, op_data, mode, result_ready,
        input  clear, busy, result, result_valid
    );

    modport slave (
        input  full, op_data, mode, result_ready,
        output clear, busy, result, result_valid
    );
endinterface

// File: rtl/operand_accum.sv
// Snapshots four operands from the tracker when full, reduces them serially
// (sum/max/min/xor) over four cycles and offers the result on a valid/ready port.
module operand_accum #(
    parameter int unsigned W = 8
) (
    input  logic            clock,
    input  logic            rst,
    operand_accum_if.slave  bus
);
    localparam int unsigned AW   = W + 2;
    localparam int unsigned NOPS = 4;
    localparam int unsigned IDXW = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [NOPS*W-1:0]  ops_q, ops_d;
    logic [1:0]         mode_q, mode_d;
    logic               clear_q, clear_d;
    logic               busy_q, busy_d;
    logic [AW-1:0]      result_q, result_d;
    logic               valid_q, valid_d;
    logic [AW-1:0]      cur_op_c;

    // One reduction step on W+2-bit values; the sum of four W-bit operands cannot overflow
    function automatic logic [AW-1:0] reduce_step(
        input logic [1:0]    md,
        input logic [AW-1:0] a,
        input logic [AW-1:0] b
    );
        logic [AW-1:0] r;
        case (md)
            2'b00:   r = a + b;
            2'b01:   r = (a > b) ? a : b;
            2'b10:   r = (a < b) ? a : b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    assign cur_op_c = AW'(ops_q[32'(idx_q) * W +: W]);

    // Next-state and datapath; only the captured operands/mode feed the reduction
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        ops_d    = ops_q;
        mode_d   = mode_q;
        clear_d  = 1'b0;
        result_d = result_q;
        valid_d  = valid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.full) begin
                    state_d = S_ACC;
                    idx_d   = '0;
                    ops_d   = bus.op_data;
                    mode_d  = bus.mode;
                    clear_d = 1'b1;
                end
            end
            S_ACC: begin
                if (idx_q == '0) begin
                    acc_d = cur_op_c;
                end else begin
                    acc_d = reduce_step(mode_q, acc_q, cur_op_c);
                end
                idx_d = idx_q + IDXW'(1);
                if (idx_q == IDXW'(NOPS - 1)) begin
                    state_d  = S_DONE;
                    result_d = acc_d;
                    valid_d  = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.result_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset discards any operation in flight
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            ops_q    <= '0;
            mode_q   <= '0;
            clear_q  <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            ops_q    <= ops_d;
            mode_q   <= mode_d;
            clear_q  <= clear_d;
            busy_q   <= busy_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.clear        = clear_q;
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
endmodule

// File: doc/operand_accum.md
# operand_accum

Downstream consumer of the four-operand tracking stage. It waits for the tracker's `full` flag, snapshots the four operand registers and the operation mode, and reduces the operands serially over four cycles. It presents the result on a valid/ready output port and issues a single-cycle `clear` pulse back to the tracker so the tracker can refill while the reduction runs.

## Interface
- `W`, default 8: width of each operand, unsigned.
- `clock`  in  1  rising-edge clock for all state.
- `rst`  in  1  asynchronous, active-high reset.
- `full`  in  1  from tracker; high when all four operands are loaded.
- `op_data`  in  4*W  operands; operand i is `op_data[i*W +: W]`.
- `mode`  in  2  operation select, sampled only at capture: 00 sum, 01 max, 10 min, 11 xor.
- `clear`  out  1  one-cycle pulse to the tracker's `clear` input.
- `busy`  out  1  high in every state other than IDLE.
- `result`  out  W+2  reduction result, zero-extended.
- `result_valid`  out  1  result is available.
- `result_ready`  in  1  downstream accepts the result.

## Operation
- States:
  - IDLE: waits for `full`.
  - ACC: four cycles, operand index `idx` runs 0..3.
  - DONE: holds the result until it is accepted.
- IDLE -> ACC:
  - Occurs at the edge where `full`=1.
  - At that edge, `op_data` and `mode` are captured into internal registers, `idx`<=0, and `clear`<=1.
- ACC, per cycle:
  - `idx`=0: acc <= zero-extended op0 (every mode).
  - `idx`=1..3: acc <= f(acc, op[idx]), where f is one of:
    - sum: unsigned add, W+2 bits, never overflows.
    - max: unsigned maximum.
    - min: unsigned minimum.
    - xor: bitwise xor on the zero-extended operand.
  - `idx` increments each cycle. After `idx`=3 the state moves to DONE.
- DONE:
  - `result_valid`=1 and `result`=acc.
  - `result` and `result_valid` stay stable until `result_valid`&&`result_ready` at an edge; the state then returns to IDLE and `result_valid`<=0.
- `clear` is a registered output. It is high for exactly the one cycle after capture, and low in every other cycle.
- `full` is ignored outside IDLE, including the cycle in which `clear` is high (the tracker still shows `full` that cycle).
- Only the captured copies of `op_data` and `mode` are used. Changes on those inputs after capture have no effect on the running operation.
- `result_ready` is ignored outside DONE.

## Timing
- Reset values:
  - state = IDLE, `idx` = 0, acc = 0.
  - `clear` = 0, `busy` = 0, `result` = 0, `result_valid` = 0.
- Reset mid-operation: the block returns to IDLE immediately (asynchronously). Any captured operands and partial result are discarded, and `clear` drops at once.
- Latency: edge E0 captures the operands (`full` sampled high). `clear` is high during cycle E0..E1. ACC runs E0..E4. `result_valid` rises after E4, i.e. 4 cycles after capture.
- Back-to-back operation:
  - DONE->IDLE at edge Ek; IDLE re-samples `full` at Ek+1.
  - Minimum spacing between captures is 6 cycles (with `result_ready` held high).
- Tracker interaction: the tracker gives `clear` priority over its enables. Any operand enable asserted during the `clear` cycle is lost, and upstream must not load in that cycle. After the `clear` cycle, the tracker may refill while ACC/DONE runs.
- Backpressure: DONE may last any number of cycles. A new `full` during DONE is held off until the block returns to IDLE.

## Test plan
- Reset, then `mode`=00, operands 0x01,0x02,0x03,0x04, `full`=1, `result_ready`=1. Required:
  - `clear` high for exactly one cycle after capture.
  - `result_valid` 4 cycles after capture, `result`=10.
  - Return to IDLE.
- `mode`=00, all operands 0xFF. Required: `result`=0x3FC (1020), no truncation.
- `mode`=01 with 0x10,0x80,0x7F,0x03, then `mode`=10 with the same operands. Required: `result`=0x80, then `result`=0x03.
- `mode`=11, operands 0xF0,0x0F,0xFF,0x01. Required: `result`=0x01.
- Backpressure:
  - Stimulus: `result_ready`=0 for 5 cycles in DONE, with `op_data`, `mode` and `full` toggled during that time.
  - Required: `result` and `result_valid` stay stable; no recapture and no second `clear` until acceptance; the next capture occurs 1 cycle after acceptance if `full`=1.
- Reset mid-operation:
  - Stimulus: assert `rst` during ACC `idx`=2.
  - Required: `busy`, `clear` and `result_valid` fall immediately and `result`=0. After release, a fresh `full` produces a correct result.
